// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and buffered LSU results onto the regfile write port
// and tracks busy long-latency destinations. Define WB_BYPASS_EN to let an LSU result skip an empty FIFO.
module wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  input  logic [4:0]                    alu_rd,
  input  logic [XLEN-1:0]               alu_data,
  input  logic                          lsu_valid,
  output logic                          lsu_ready,
  input  logic [4:0]                    lsu_rd,
  input  logic [XLEN-1:0]               lsu_data,
  input  logic                          issue_valid,
  input  logic [4:0]                    issue_rd,
  input  logic [4:0]                    ra1,
  input  logic [4:0]                    ra2,
  input  logic [4:0]                    rd_q,
  output logic                          hazard,
  output logic                          we,
  output logic [4:0]                    wa,
  output logic [XLEN-1:0]               wd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [4:0]      mem_rd_r   [FIFO_DEPTH];
  logic [XLEN-1:0] mem_data_r [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [31:0]     busy_r;
  logic            we_r;
  logic [4:0]      wa_r;
  logic [XLEN-1:0] wd_r;

  logic            bypass_s;
  logic            push_s;
  logic            pop_s;
  logic            sel_valid_s;
  logic [4:0]      sel_rd_s;
  logic [XLEN-1:0] sel_data_s;
  logic            clr_s;
  logic [CW-1:0]   count_nxt_s;
  logic [31:0]     clr_mask_s;
  logic [31:0]     set_mask_s;
  logic [31:0]     busy_nxt_s;

  assign lsu_ready  = (count_r < DEPTH_C);
  assign fifo_count = count_r;
  assign we         = we_r;
  assign wa         = wa_r;
  assign wd         = wd_r;

  // Decode hazard: any nonzero queried register with a pending long-latency write
  assign hazard = ((ra1  != 5'd0) && busy_r[ra1]) ||
                  ((ra2  != 5'd0) && busy_r[ra2]) ||
                  ((rd_q != 5'd0) && busy_r[rd_q]);

  // Write-source selection: ALU first, then FIFO head, then (optionally) direct LSU bypass
  always_comb begin
    bypass_s    = 1'b0;
`ifdef WB_BYPASS_EN
    bypass_s    = !alu_valid && (count_r == {CW{1'b0}}) && lsu_valid;
`else
    bypass_s    = 1'b0;
`endif
    push_s      = lsu_valid && lsu_ready && !bypass_s;
    pop_s       = !alu_valid && (count_r != {CW{1'b0}});
    sel_valid_s = 1'b0;
    sel_rd_s    = 5'd0;
    sel_data_s  = {XLEN{1'b0}};
    clr_s       = 1'b0;
    if (alu_valid) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = alu_rd;
      sel_data_s  = alu_data;
    end else if (pop_s) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = mem_rd_r[rd_ptr_r];
      sel_data_s  = mem_data_r[rd_ptr_r];
      clr_s       = 1'b1;
    end else if (bypass_s) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = lsu_rd;
      sel_data_s  = lsu_data;
      clr_s       = 1'b1;
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  // Occupancy and scoreboard next-state; a set in the same cycle overrides a clear
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
    clr_mask_s = clr_s ? (32'd1 << sel_rd_s) : 32'd0;
    set_mask_s = (issue_valid && (issue_rd != 5'd0)) ? (32'd1 << issue_rd) : 32'd0;
    busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~32'd1;
  end

  // Control state and registered write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_r     <= 1'b0;
      wa_r     <= 5'd0;
      wd_r     <= {XLEN{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      busy_r   <= 32'd0;
    end else begin
      we_r <= sel_valid_s && (sel_rd_s != 5'd0);
      if (sel_valid_s) begin
        wa_r <= sel_rd_s;
        wd_r <= sel_data_s;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // FIFO storage; stale contents are unreachable once pointers reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_rd_r[wr_ptr_r]   <= lsu_rd;
      mem_data_r[wr_ptr_r] <= lsu_data;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table, directed corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [4:0]      ra1, ra2, rd_q;
  logic            hazard;
  logic            we;
  logic [4:0]      wa;
  logic [XLEN-1:0] wd;
  logic [CW-1:0]   fifo_count;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .ra1(ra1), .ra2(ra2), .rd_q(rd_q), .hazard(hazard),
    .we(we), .wa(wa), .wd(wd), .fifo_count(fifo_count)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        exp_we;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
  } vec_t;

  ent_t        q[$];
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  bit          m_acc;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_hazard();
    return ((ra1 != 5'd0) && m_busy[ra1]) || ((ra2 != 5'd0) && m_busy[ra2]) ||
           ((rd_q != 5'd0) && m_busy[rd_q]);
  endfunction

  // Reference: one cycle of the arbitration rules applied to the current inputs
  task automatic model_step();
    bit   ready;
    bit   byp;
    bit   clr;
    ent_t h;
    ready = (q.size() < DEPTH);
    byp   = BYP && !alu_valid && (q.size() == 0) && lsu_valid;
    clr   = 1'b0;
    m_acc = lsu_valid && ready;
    m_we  = 1'b0;
    if (alu_valid) begin
      m_we = (alu_rd != 5'd0); m_wa = alu_rd; m_wd = alu_data;
    end else if (q.size() > 0) begin
      h = q.pop_front();
      m_we = (h.rd != 5'd0); m_wa = h.rd; m_wd = h.data; clr = 1'b1;
    end else if (byp) begin
      m_we = (lsu_rd != 5'd0); m_wa = lsu_rd; m_wd = lsu_data; clr = 1'b1;
    end
    if (lsu_valid && ready && !byp) q.push_back('{rd: lsu_rd, data: lsu_data});
    if (clr) m_busy[m_wa] = 1'b0;
    if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
    m_busy[0] = 1'b0;
  endtask

  task automatic compare_all();
    chk("we", 32'(we), 32'(m_we));
    if (m_we) begin
      chk("wa", 32'(wa), 32'(m_wa));
      chk("wd", wd, m_wd);
    end
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("lsu_ready", 32'(lsu_ready), 32'(q.size() < DEPTH));
    chk("hazard", 32'(hazard), 32'(m_hazard()));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
    issue_valid = 1'b0; issue_rd = 5'd0;
    ra1 = 5'd0; ra2 = 5'd0; rd_q = 5'd0;
  endtask

  task automatic reset_and_check(input string tag);
    reset = 1'b1;
    #2;
    q.delete(); m_busy = 32'd0; m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0;
    chk({tag, "_we"}, 32'(we), 32'd0);
    chk({tag, "_wa"}, 32'(wa), 32'd0);
    chk({tag, "_wd"}, wd, 32'd0);
    chk({tag, "_count"}, 32'(fifo_count), 32'd0);
    chk({tag, "_hazard"}, 32'(hazard), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  vec_t        vt[6];
  logic [4:0]  got[$];
  logic [4:0]  exp_order[3];
  logic [4:0]  items_rd[3];
  int          idx;
  int          nw;
  int          lat;

  initial begin
    idle();
    reset_and_check("reset");

    // Single-cycle ALU writes from an idle arbiter
    vt[0] = '{1'b1, 5'd5,  32'h0000_1234, 1'b1, 5'd5,  32'h0000_1234};
    vt[1] = '{1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000};
    vt[2] = '{1'b1, 5'd0,  32'hDEAD_BEEF, 1'b0, 5'd0,  32'h0000_0000};
    vt[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF};
    vt[4] = '{1'b1, 5'd1,  32'h0000_0000, 1'b1, 5'd1,  32'h0000_0000};
    vt[5] = '{1'b0, 5'd9,  32'h1111_1111, 1'b0, 5'd0,  32'h0000_0000};
    for (int i = 0; i < 6; i++) begin
      alu_valid = vt[i].alu_valid; alu_rd = vt[i].alu_rd; alu_data = vt[i].alu_data;
      cycle();
      chk("vec_we", 32'(we), 32'(vt[i].exp_we));
      if (vt[i].exp_we) begin
        chk("vec_wa", 32'(wa), 32'(vt[i].exp_wa));
        chk("vec_wd", wd, vt[i].exp_wd);
      end
    end
    idle();

    // Scoreboard set by issue, cleared by the LSU write-back
    issue_valid = 1'b1; issue_rd = 5'd7;
    cycle();
    issue_valid = 1'b0; ra1 = 5'd7;
    #1 chk("hazard_set", 32'(hazard), 32'd1);
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hAA;
    cycle();
    lsu_valid = 1'b0;
    repeat (3) cycle();
    chk("hazard_cleared", 32'(hazard), 32'd0);
    idle();

    // Continuous ALU traffic starves the FIFO until it fills
    items_rd = '{5'd3, 5'd4, 5'd5};
    exp_order = '{5'd3, 5'd4, 5'd5};
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'(i);
      lsu_valid = (idx < 3);
      lsu_rd = items_rd[idx < 3 ? idx : 2]; lsu_data = 32'h300 + 32'(idx);
      cycle();
      if (m_acc) idx++;
    end
    chk("starve_count", 32'(fifo_count), 32'd2);
    chk("starve_ready", 32'(lsu_ready), 32'd0);
    alu_valid = 1'b0;
    got.delete();
    for (int i = 0; i < 10; i++) begin
      lsu_valid = (idx < 3);
      lsu_rd = items_rd[idx < 3 ? idx : 2]; lsu_data = 32'h300 + 32'(idx);
      cycle();
      if (m_acc) idx++;
      if (we) got.push_back(wa);
    end
    chk("starve_nwrites", 32'(got.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      chk("starve_order", (k < got.size()) ? 32'(got[k]) : 32'hFFFF_FFFF, 32'(exp_order[k]));
    idle();

    // x0 destinations: consumed but never written, busy untouched
    issue_valid = 1'b1; issue_rd = 5'd12;
    cycle();
    issue_valid = 1'b0; ra1 = 5'd12;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h77;
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h88;
    nw = 0;
    cycle();
    if (we) nw++;
    alu_valid = 1'b0; lsu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (we) nw++;
    end
    chk("x0_no_write", 32'(nw), 32'd0);
    chk("x0_drained", 32'(fifo_count), 32'd0);
    chk("x0_busy_kept", 32'(hazard), 32'd1);
    idle();

    // Asynchronous reset with two LSU results buffered
    issue_valid = 1'b1; issue_rd = 5'd20;
    cycle();
    issue_rd = 5'd21; ra1 = 5'd20;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
    lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'hA20;
    cycle();
    issue_valid = 1'b0;
    lsu_rd = 5'd21; lsu_data = 32'hA21;
    cycle();
    lsu_valid = 1'b0;
    cycle();
    chk("pre_reset_count", 32'(fifo_count), 32'd2);
    #3;
    reset_and_check("midreset");
    alu_valid = 1'b0;
    nw = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (we) nw++;
    end
    chk("post_reset_no_write", 32'(nw), 32'd0);
    idle();

    // LSU latency from an empty FIFO with the ALU idle
    lat = 0;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h55;
    for (int c = 1; c <= 4; c++) begin
      cycle();
      lsu_valid = 1'b0;
      if (lat == 0 && we === 1'b1 && wa === 5'd9) lat = c;
    end
    chk("lsu_latency", 32'(lat), BYP ? 32'd1 : 32'd2);
    idle();

    // Randomized traffic; a stalled LSU source holds rd/data
    for (int i = 0; i < 3000; i++) begin
      alu_valid = ($urandom_range(0, 99) < 45);
      alu_rd = 5'($urandom); alu_data = $urandom;
      if (!(lsu_valid && !m_acc)) begin
        lsu_valid = ($urandom_range(0, 99) < 50);
        lsu_rd = 5'($urandom_range(0, 7)); lsu_data = $urandom;
      end
      issue_valid = ($urandom_range(0, 99) < 20);
      issue_rd = 5'($urandom_range(0, 7));
      ra1 = 5'($urandom_range(0, 7)); ra2 = 5'($urandom_range(0, 7));
      rd_q = 5'($urandom_range(0, 7));
      m_acc = 1'b0;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
